// File: rtl/ccd_timing_pkg.sv
// Shared timing definitions for the CCD phase generator.
//   - CCD_CNT_W    : default width of every timing/count field
//   - ST_IDLE..ST_GAP2 : 3-bit FSM state encoding
//   - clamp_to_one : maps a zero-valued field to 1
package ccd_timing_pkg;

  localparam int unsigned CCD_CNT_W = 8;

  typedef logic [2:0] ccd_state_t;

  localparam ccd_state_t ST_IDLE = 3'd0;
  localparam ccd_state_t ST_RST  = 3'd1;
  localparam ccd_state_t ST_GAP1 = 3'd2;
  localparam ccd_state_t ST_PIX  = 3'd3;
  localparam ccd_state_t ST_GAP2 = 3'd4;

  // Operates on a 32-bit container so callers of any field width can share it.
  function automatic logic [31:0] clamp_to_one(input logic [31:0] v);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

endpackage

// File: rtl/ccd_phase_counter.sv
// Loadable down-counter with enable and zero flag.
// Ports:
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   load_i        : load load_val_i (has priority over en_i)
//   en_i          : decrement by one; holds at zero
//   load_val_i    : value to load
//   zero_o        : high when the count is zero
module ccd_phase_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ccd_phase_generator.sv
// CCD readout phase generator: emits non-overlapping reset-gate (o_phi_r) and
// pixel-transfer (o_phi_p) phases with programmable widths and dead time, for a
// programmed number of pixel cycles per line.
// Ports:
//   i_clk, i_rst         : clock, asynchronous active-high reset
//   i_start, i_abort     : line start request (IDLE only), synchronous abort
//   i_t_r, i_t_gap, i_t_p, i_n_pix : timing config, latched on accepted start
//   i_sel_manual         : selector source when SELECTOR_AUTO_EN is not defined
//   o_phi_r, o_phi_p     : phase outputs (registered)
//   o_selector           : downstream mux select (1 = phi_r path)
//   o_busy, o_done       : line in progress, one-cycle end-of-line pulse
// Build option: define SELECTOR_AUTO_EN to drive o_selector from the FSM
// (high in RST and GAP1) instead of from i_sel_manual.
module ccd_phase_generator
  import ccd_timing_pkg::*;
#(
  parameter int unsigned CNT_W = CCD_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [CNT_W-1:0] i_t_r,
  input  logic [CNT_W-1:0] i_t_gap,
  input  logic [CNT_W-1:0] i_t_p,
  input  logic [CNT_W-1:0] i_n_pix,
  input  logic             i_sel_manual,
  output logic             o_phi_r,
  output logic             o_phi_p,
  output logic             o_selector,
  output logic             o_busy,
  output logic             o_done
);

  typedef logic [CNT_W-1:0] cnt_t;

  // Counters hold (value - 1) so terminal count is zero.
  function automatic cnt_t load_of(input cnt_t v);
    return cnt_t'(clamp_to_one(32'(v)) - 32'd1);
  endfunction

  ccd_state_t state_q, state_d;

  cnt_t t_r_q, t_gap_q, t_p_q;
  logic cfg_load;

  logic tmr_load, tmr_en, tmr_zero;
  cnt_t tmr_val;
  logic pix_load, pix_en, pix_zero;
  cnt_t pix_val;
  logic pix_end;

  logic phi_r_q, phi_p_q, sel_q, busy_q, done_q;
  logic phi_r_d, phi_p_d, sel_d, busy_d, done_d;

  ccd_phase_counter #(.CNT_W(CNT_W)) u_phase_tmr (
    .clk_i      (i_clk),
    .rst_i      (i_rst),
    .load_i     (tmr_load),
    .en_i       (tmr_en),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  ccd_phase_counter #(.CNT_W(CNT_W)) u_pix_cnt (
    .clk_i      (i_clk),
    .rst_i      (i_rst),
    .load_i     (pix_load),
    .en_i       (pix_en),
    .load_val_i (pix_val),
    .zero_o     (pix_zero)
  );

  // State register and config latch
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      t_r_q   <= '0;
      t_gap_q <= '0;
      t_p_q   <= '0;
    end else begin
      state_q <= state_d;
      if (cfg_load) begin
        t_r_q   <= i_t_r;
        t_gap_q <= i_t_gap;
        t_p_q   <= i_t_p;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    cfg_load = 1'b0;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    tmr_val  = '0;
    pix_load = 1'b0;
    pix_en   = 1'b0;
    pix_val  = '0;
    pix_end  = 1'b0;
    done_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          // Timer loads from the live inputs: the latch is not yet valid.
          state_d  = ST_RST;
          cfg_load = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = load_of(i_t_r);
          pix_load = 1'b1;
          pix_val  = load_of(i_n_pix);
        end
      end
      ST_RST: begin
        if (!tmr_zero) begin
          tmr_en = 1'b1;
        end else if (t_gap_q != '0) begin
          state_d  = ST_GAP1;
          tmr_load = 1'b1;
          tmr_val  = t_gap_q - cnt_t'(1);
        end else begin
          state_d  = ST_PIX;
          tmr_load = 1'b1;
          tmr_val  = load_of(t_p_q);
        end
      end
      ST_GAP1: begin
        if (!tmr_zero) begin
          tmr_en = 1'b1;
        end else begin
          state_d  = ST_PIX;
          tmr_load = 1'b1;
          tmr_val  = load_of(t_p_q);
        end
      end
      ST_PIX: begin
        if (!tmr_zero) begin
          tmr_en = 1'b1;
        end else if (t_gap_q != '0) begin
          state_d  = ST_GAP2;
          tmr_load = 1'b1;
          tmr_val  = t_gap_q - cnt_t'(1);
        end else begin
          pix_end = 1'b1;
        end
      end
      ST_GAP2: begin
        if (!tmr_zero) begin
          tmr_en = 1'b1;
        end else begin
          pix_end = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (pix_end) begin
      if (pix_zero) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end else begin
        state_d  = ST_RST;
        pix_en   = 1'b1;
        tmr_load = 1'b1;
        tmr_val  = load_of(t_r_q);
      end
    end

    // Abort wins over everything, including a start in IDLE.
    if (i_abort) begin
      state_d  = ST_IDLE;
      cfg_load = 1'b0;
      tmr_load = 1'b0;
      tmr_en   = 1'b0;
      pix_load = 1'b0;
      pix_en   = 1'b0;
      done_d   = 1'b0;
    end
  end

  // Output decode from next state so the registered outputs line up with state_q.
  always_comb begin
    phi_r_d = (state_d == ST_RST);
    phi_p_d = (state_d == ST_PIX);
    busy_d  = (state_d != ST_IDLE);
`ifdef SELECTOR_AUTO_EN
    sel_d   = (state_d == ST_RST) || (state_d == ST_GAP1);
`else
    sel_d   = i_sel_manual;
`endif
  end

`ifdef SELECTOR_AUTO_EN
  logic unused_sel_manual;
  assign unused_sel_manual = i_sel_manual;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      phi_r_q <= 1'b0;
      phi_p_q <= 1'b0;
      sel_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      phi_r_q <= phi_r_d;
      phi_p_q <= phi_p_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_phi_r    = phi_r_q;
  assign o_phi_p    = phi_p_q;
  assign o_selector = sel_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;

endmodule

// File: tb/tb_ccd_phase_generator.sv
// Self-checking bench for ccd_phase_generator: directed line scenarios plus
// randomized stimulus against a cycle-offset reference model.
module tb_ccd_phase_generator;

  localparam int unsigned CntW = 8;

  logic            clk;
  logic            rst;
  logic            start;
  logic            abort_in;
  logic            sel_manual;
  logic [CntW-1:0] t_r, t_gap, t_p, n_pix;
  logic            phi_r, phi_p, selector, busy, done;

  int unsigned n_compared;
  int unsigned n_mismatched;

  // Reference model: line position expressed as cycles elapsed since start.
  bit m_active, m_done, m_sel;
  int m_tr, m_g, m_tp, m_n, m_k;

  ccd_phase_generator #(.CNT_W(CntW)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_abort      (abort_in),
    .i_t_r        (t_r),
    .i_t_gap      (t_gap),
    .i_t_p        (t_p),
    .i_n_pix      (n_pix),
    .i_sel_manual (sel_manual),
    .o_phi_r      (phi_r),
    .o_phi_p      (phi_p),
    .o_selector   (selector),
    .o_busy       (busy),
    .o_done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int clamp1(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  // Applies the inputs seen at a rising edge to the model.
  task automatic model_update();
    int per;
    m_done = 1'b0;
    if (rst) begin
      m_active = 1'b0;
      m_sel    = 1'b0;
      m_k      = 0;
    end else begin
      per = m_tr + m_tp + 2 * m_g;
      if (abort_in) begin
        m_active = 1'b0;
      end else if (m_active) begin
        if (m_k + 1 == m_n * per) begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end else begin
          m_k++;
        end
      end else if (start) begin
        m_tr     = clamp1(int'(t_r));
        m_g      = int'(t_gap);
        m_tp     = clamp1(int'(t_p));
        m_n      = clamp1(int'(n_pix));
        m_k      = 0;
        m_active = 1'b1;
      end
      m_sel = sel_manual;
    end
  endtask

  task automatic check_outputs();
    int per, p;
    bit er, ep, es;
    er = 1'b0;
    ep = 1'b0;
    es = 1'b0;
    if (m_active) begin
      per = m_tr + m_tp + 2 * m_g;
      p   = m_k % per;
      er  = (p < m_tr);
      ep  = (p >= m_tr + m_g) && (p < m_tr + m_g + m_tp);
      es  = (p < m_tr + m_g);
    end
`ifndef SELECTOR_AUTO_EN
    es = m_sel;
`endif
    check_eq("phi_r", 32'(phi_r), 32'(er));
    check_eq("phi_p", 32'(phi_p), 32'(ep));
    check_eq("busy", 32'(busy), 32'(m_active));
    check_eq("done", 32'(done), 32'(m_done));
    check_eq("selector", 32'(selector), 32'(es));
    check_eq("overlap", 32'(phi_r & phi_p), 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_outputs();
  endtask

  // Runs a line for a fixed cycle budget, tallying observations for the
  // directed end-to-end checks. done_at stays -1 if o_done never shows up.
  task automatic run_line(input int max_cyc, input bit disturb,
                          output int done_at, output int busy_cnt,
                          output int r_cnt, output int p_cnt);
    done_at  = -1;
    busy_cnt = 0;
    r_cnt    = 0;
    p_cnt    = 0;
    start    = 1'b1;
    for (int i = 1; i <= max_cyc; i++) begin
      step();
      start = 1'b0;
      if (disturb && i == 3) begin
        start = 1'b1;
        t_p   = 8'd9;
      end
      if (busy)  busy_cnt++;
      if (phi_r) r_cnt++;
      if (phi_p) p_cnt++;
      if (done && done_at < 0) done_at = i;
    end
  endtask

  task automatic set_cfg(input int tr, input int tg, input int tp, input int np);
    t_r   = CntW'(tr);
    t_gap = CntW'(tg);
    t_p   = CntW'(tp);
    n_pix = CntW'(np);
  endtask

  initial begin
    int d_at, b_cnt, r_cnt, p_cnt;
    n_compared   = 0;
    n_mismatched = 0;
    m_active = 1'b0;
    m_done   = 1'b0;
    m_sel    = 1'b0;
    m_k      = 0;
    m_tr     = 1;
    m_g      = 0;
    m_tp     = 1;
    m_n      = 1;
    rst        = 1'b1;
    start      = 1'b0;
    abort_in   = 1'b0;
    sel_manual = 1'b0;
    set_cfg(0, 0, 0, 0);

    // Reset state
    step();
    step();
    rst = 1'b0;
    step();

    // Basic line
    set_cfg(2, 1, 3, 2);
    run_line(17, 1'b0, d_at, b_cnt, r_cnt, p_cnt);
    check_eq("s1_done_cycle", 32'(d_at), 32'd15);
    check_eq("s1_busy_cycles", 32'(b_cnt), 32'd14);
    check_eq("s1_phi_r_cycles", 32'(r_cnt), 32'd4);
    check_eq("s1_phi_p_cycles", 32'(p_cnt), 32'd6);

    // Zero gap and clamps
    set_cfg(0, 0, 0, 0);
    run_line(5, 1'b0, d_at, b_cnt, r_cnt, p_cnt);
    check_eq("s2_done_cycle", 32'(d_at), 32'd3);
    check_eq("s2_busy_cycles", 32'(b_cnt), 32'd2);

    // Start while busy plus mid-line config change
    set_cfg(2, 1, 3, 2);
    run_line(17, 1'b1, d_at, b_cnt, r_cnt, p_cnt);
    check_eq("s3_done_cycle", 32'(d_at), 32'd15);
    check_eq("s3_busy_cycles", 32'(b_cnt), 32'd14);
    check_eq("s3_phi_p_cycles", 32'(p_cnt), 32'd6);

    // Abort during PIX of the first pixel, then a fresh full line
    set_cfg(2, 1, 3, 2);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 2; i <= 4; i++) step();
    check_eq("s4_in_pix", 32'(phi_p), 32'd1);
    abort_in = 1'b1;
    step();
    abort_in = 1'b0;
    check_eq("s4_idle_busy", 32'(busy), 32'd0);
    d_at = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done) d_at++;
    end
    check_eq("s4_no_done", 32'(d_at), 32'd0);
    run_line(17, 1'b0, d_at, b_cnt, r_cnt, p_cnt);
    check_eq("s4_restart_done", 32'(d_at), 32'd15);
    check_eq("s4_restart_busy", 32'(b_cnt), 32'd14);

    // Async reset between edges during RST
    set_cfg(2, 1, 3, 2);
    sel_manual = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check_eq("s5_in_rst", 32'(phi_r), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("s5_async_phi_r", 32'(phi_r), 32'd0);
    check_eq("s5_async_busy", 32'(busy), 32'd0);
    check_eq("s5_async_sel", 32'(selector), 32'd0);
    check_eq("s5_async_done", 32'(done), 32'd0);
    step();
    rst = 1'b0;
    sel_manual = 1'b0;
    for (int i = 0; i < 4; i++) step();

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      start      = ($urandom_range(0, 5) == 0);
      abort_in   = ($urandom_range(0, 60) == 0);
      sel_manual = $urandom_range(0, 1) == 1;
      set_cfg($urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 4),
              $urandom_range(0, 3));
      step();
    end
    start    = 1'b0;
    abort_in = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
